// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply blocks: FSM encoding and packing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flat element index of (row, col) in a row-major dim x dim matrix.
    function automatic int elem_idx(input int row, input int col, input int dim);
        return row * dim + col;
    endfunction

    // Width of an index counter covering 0..dim-1, never narrower than one bit.
    function automatic int cnt_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/multip_adder.sv
// Combinational signed multiply-accumulate: out = in_a * in_b + in_c.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller owns all sequencing and registers.
module multip_adder #(
    parameter int BITWIDTH                 = 8,
    parameter int IS_BITWIDTH_DOUBLE_SCALE = 1
) (
    input  logic signed [BITWIDTH-1:0]                                    in_a,
    input  logic signed [BITWIDTH-1:0]                                    in_b,
    input  logic signed [(IS_BITWIDTH_DOUBLE_SCALE ? 2 : 1)*BITWIDTH-1:0] in_c,
    output logic signed [(IS_BITWIDTH_DOUBLE_SCALE ? 2 : 1)*BITWIDTH-1:0] out
);

    localparam int OW = (IS_BITWIDTH_DOUBLE_SCALE ? 2 : 1) * BITWIDTH;

    logic signed [2*BITWIDTH-1:0] prod;

    // Full-precision product, then a wrapping add at the output width.
    always_comb begin
        prod = in_a * in_b;
        out  = prod[OW-1:0] + in_c;
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequential C = A x B controller time-multiplexing one MAC over the i/j/k index space.
// Latency: DIM^3 + 1 edges from accepted start to the done pulse.
// Backpressure: start is ignored while busy; no queueing, start in DONE is accepted back-to-back.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int DIM      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DIM*DIM*BITWIDTH-1:0]       mat_a,
    input  logic [DIM*DIM*BITWIDTH-1:0]       mat_b,
    output logic                              busy,
    output logic                              done,
    output logic                              c_valid,
    output logic [DIM*DIM*2*BITWIDTH-1:0]     mat_c
);

    localparam int             CW   = cnt_width(DIM);
    localparam int             AW   = 2 * BITWIDTH;
    localparam logic [CW-1:0]  LAST = CW'(DIM - 1);

    state_t                        state_q;
    logic [CW-1:0]                 i_q, j_q, k_q;
    logic signed [AW-1:0]          acc_q;
    logic signed [AW-1:0]          acc_d;
    logic [DIM*DIM*BITWIDTH-1:0]   a_q, b_q;
    logic [DIM*DIM*AW-1:0]         c_q;
    logic                          busy_q, done_q, c_valid_q;

    logic signed [BITWIDTH-1:0]    op_a, op_b;
    logic signed [AW-1:0]          op_c;

    // Operand selection: A[i][k], B[k][j], and a fresh accumulator at the start of each dot product.
    always_comb begin
        op_a = a_q[elem_idx(int'(i_q), int'(k_q), DIM)*BITWIDTH +: BITWIDTH];
        op_b = b_q[elem_idx(int'(k_q), int'(j_q), DIM)*BITWIDTH +: BITWIDTH];
        op_c = (k_q == '0) ? '0 : acc_q;
    end

    multip_adder #(
        .BITWIDTH                 (BITWIDTH),
        .IS_BITWIDTH_DOUBLE_SCALE (1)
    ) u_mac (
        .in_a (op_a),
        .in_b (op_b),
        .in_c (op_c),
        .out  (acc_d)
    );

    // Control FSM: operand capture, index counters, result write-back and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            c_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q       <= mat_a;
                        b_q       <= mat_b;
                        c_q       <= '0;
                        c_valid_q <= 1'b0;
                        i_q       <= '0;
                        j_q       <= '0;
                        k_q       <= '0;
                        acc_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (k_q == LAST) begin
                        // Last term of the dot product goes straight to C, bypassing the accumulator.
                        c_q[elem_idx(int'(i_q), int'(j_q), DIM)*AW +: AW] <= acc_d;
                        k_q <= '0;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            if (i_q == LAST) begin
                                i_q       <= '0;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                c_valid_q <= 1'b1;
                                state_q   <= ST_DONE;
                            end else begin
                                i_q <= i_q + CW'(1);
                            end
                        end else begin
                            j_q <= j_q + CW'(1);
                        end
                    end else begin
                        acc_q <= acc_d;
                        k_q   <= k_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign c_valid = c_valid_q;
    assign mat_c   = c_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl at DIM=2/BITWIDTH=8 and DIM=3/BITWIDTH=4.
// Latency: checks done timing of DIM^3+1 edges after the accept edge.
// Backpressure: exercises start-while-busy, mid-run reset and back-to-back starts.
module tb_matmul_seq_ctrl;

    logic        clk;
    logic        rst;

    logic        start2;
    logic [31:0] mat_a2, mat_b2;
    logic        busy2, done2, c_valid2;
    logic [63:0] mat_c2;

    logic        start3;
    logic [35:0] mat_a3, mat_b3;
    logic        busy3, done3, c_valid3;
    logic [71:0] mat_c3;

    int errors = 0;
    int checks = 0;

    // Operand and expected-result vectors, packed with element (0,0) in the LSBs.
    localparam logic [31:0] A_BASIC = 32'h04030201;           // [[1,2],[3,4]]
    localparam logic [31:0] B_BASIC = 32'h08070605;           // [[5,6],[7,8]]
    localparam logic [63:0] C_BASIC = 64'h0032_002B_0016_0013; // [[19,22],[43,50]]
    localparam logic [31:0] A_MIN   = 32'h80808080;           // all -128
    localparam logic [63:0] C_MIN   = 64'h8000_8000_8000_8000; // 32768 wraps to -32768
    localparam logic [31:0] A_SGN   = 32'hFC0302FF;           // [[-1,2],[3,-4]]
    localparam logic [31:0] B_ID2   = 32'h01000001;           // identity
    localparam logic [63:0] C_SGN   = 64'hFFFC_0003_0002_FFFF;
    localparam logic [35:0] A_ID3   = 36'h100010001;
    localparam logic [35:0] B_3     = 36'hF87654321;          // [[1,2,3],[4,5,6],[7,-8,-1]]
    localparam logic [71:0] C_3     = 72'hFFF807060504030201;

    matmul_seq_ctrl #(.BITWIDTH(8), .DIM(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .mat_a   (mat_a2),
        .mat_b   (mat_b2),
        .busy    (busy2),
        .done    (done2),
        .c_valid (c_valid2),
        .mat_c   (mat_c2)
    );

    matmul_seq_ctrl #(.BITWIDTH(4), .DIM(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .start   (start3),
        .mat_a   (mat_a3),
        .mat_b   (mat_b3),
        .busy    (busy3),
        .done    (done3),
        .c_valid (c_valid3),
        .mat_c   (mat_c3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the DIM=2 instance and count edges until done (bounded).
    task automatic run2(input logic [31:0] a, input logic [31:0] b, output int lat);
        mat_a2 = a;
        mat_b2 = b;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 60) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dcount;

        rst    = 1'b1;
        start2 = 1'b0;
        start3 = 1'b0;
        mat_a2 = '0;
        mat_b2 = '0;
        mat_a3 = '0;
        mat_b3 = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_busy",    busy2,    1'b0);
        check("rst_done",    done2,    1'b0);
        check("rst_cvalid",  c_valid2, 1'b0);
        check("rst_matc",    mat_c2,   64'h0);
        check("rst3_matc",   mat_c3,   72'h0);

        // Basic product with exact latency
        run2(A_BASIC, B_BASIC, lat);
        check("basic_lat",    lat,      9);
        check("basic_matc",   mat_c2,   C_BASIC);
        check("basic_cvalid", c_valid2, 1'b1);
        check("basic_busy",   busy2,    1'b0);
        step();
        check("basic_done_1cyc", done2,    1'b0);
        step();
        step();
        check("idle_cvalid_hold", c_valid2, 1'b1);
        check("idle_matc_hold",   mat_c2,   C_BASIC);

        // Signed wrap and sign extension
        run2(A_MIN, A_MIN, lat);
        check("wrap_lat",  lat,    9);
        check("wrap_matc", mat_c2, C_MIN);
        step();
        run2(A_SGN, B_ID2, lat);
        check("sgn_matc",  mat_c2, C_SGN);

        // Busy protection: start with other operands on every RUN cycle
        step();
        mat_a2 = A_BASIC;
        mat_b2 = B_BASIC;
        start2 = 1'b1;
        step();
        check("prot_cvalid_drop", c_valid2, 1'b0);
        check("prot_busy",        busy2,    1'b1);
        dcount = 0;
        for (int n = 1; n <= 8; n++) begin
            if (done2) dcount++;
            start2 = 1'b1;
            mat_a2 = A_MIN;
            mat_b2 = A_SGN;
            step();
        end
        start2 = 1'b0;
        check("prot_done_at9", done2,  1'b1);
        check("prot_matc",     mat_c2, C_BASIC);
        for (int n = 0; n < 12; n++) begin
            if (done2) dcount++;
            step();
        end
        check("prot_one_done", dcount, 1);
        check("prot_idle",     busy2,  1'b0);

        // Reset in cycle 4 of RUN
        mat_a2 = A_BASIC;
        mat_b2 = B_BASIC;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        step();
        step();
        check("mid_busy_pre", busy2, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_busy",   busy2,    1'b0);
        check("mid_done",   done2,    1'b0);
        check("mid_cvalid", c_valid2, 1'b0);
        check("mid_matc",   mat_c2,   64'h0);
        step();
        check("mid_stay_idle", busy2, 1'b0);
        run2(A_SGN, B_ID2, lat);
        check("mid_fresh_lat",  lat,    9);
        check("mid_fresh_matc", mat_c2, C_SGN);
        step();

        // Back-to-back with start held high
        mat_a2 = A_BASIC;
        mat_b2 = B_BASIC;
        start2 = 1'b1;
        step();
        for (int n = 1; n <= 27; n++) begin
            if (n % 9 == 0) begin
                check("b2b_done",   done2,    1'b1);
                check("b2b_matc",   mat_c2,   C_BASIC);
                check("b2b_cvalid", c_valid2, 1'b1);
            end else begin
                check("b2b_nodone", done2, 1'b0);
            end
            if (n % 9 == 1) check("b2b_cvalid_low", c_valid2, 1'b0);
            if (n == 27) start2 = 1'b0;
            step();
        end
        check("b2b_end_busy",   busy2,    1'b0);
        check("b2b_end_cvalid", c_valid2, 1'b1);

        // DIM=3, BITWIDTH=4: identity times B
        mat_a3 = A_ID3;
        mat_b3 = B_3;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        check("d3_busy", busy3, 1'b1);
        lat = 1;
        while (!done3 && lat < 100) begin
            step();
            lat++;
        end
        check("d3_lat",    lat,      28);
        check("d3_matc",   mat_c3,   C_3);
        check("d3_cvalid", c_valid3, 1'b1);
        step();
        check("d3_done_1cyc", done3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
